net_toaxistream: RTL and testbench
==================================

NET_TOAXISTREAM -- requirements
Module: net_toaxistream

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- AxiStreamIfTDataWidth, 32, tdata width; multiple of NetworkIfFlitWidth.
- AxiStreamIfTIdWidth, 4, tid width.
- AxiStreamIfTDestWidth, 4, tdest width.
- NetworkIfFlitWidth, 16, flit width; multiple of 8, at least TIdWidth+TDestWidth.
- NetworkIfFlitTypeWidth, 2, flit type width; at least 2.
- NetworkIfBroadcastWidth, 1, broadcast width.
- NetworkIfVirtualChannelIdWidth, 1, VC id width.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk_axis_i, in, 1, sole clock.
- rst_axis_ni, in, 1, reset; asynchronous, active-low.
- network_valid_i, in, 1, flit valid.
- network_ready_o, out, 1, flit accept.
- network_flit_i, in, NetworkIfFlitWidth, flit payload.
- network_flit_type_i, in, NetworkIfFlitTypeWidth, flit type.
- network_broadcast_i, in, NetworkIfBroadcastWidth, ignored.
- network_virtual_channel_id_i, in, NetworkIfVirtualChannelIdWidth, ignored (single VC).
- m_axis_tvalid_o, out, 1, beat valid.
- m_axis_tready_i, in, 1, sink ready.
- m_axis_tdata_o, out, AxiStreamIfTDataWidth, beat data.
- m_axis_tkeep_o, out, AxiStreamIfTDataWidth/8, byte valid.
- m_axis_tlast_o, out, 1, last beat of packet.
- m_axis_tid_o, out, AxiStreamIfTIdWidth, stream id.
- m_axis_tdest_o, out, AxiStreamIfTDestWidth, destination.
- protocol_error_o, out, 1, sticky malformed-packet flag.

Function
REQ-003 Flit types SHALL be decoded from type[1:0], with higher bits ignored:
- 0 = HEADER; 1 = BODY; 2 = TAIL; 3 = HEADER_TAIL.
REQ-004 A HEADER flit SHALL carry tdest in bits [TDestWidth-1:0] and tid in the next TIdWidth bits; remaining bits SHALL be ignored; a HEADER SHALL carry no data.
REQ-005 A BODY or TAIL flit SHALL carry NetworkIfFlitWidth data bits.
REQ-006 A flit SHALL be consumed on a rising edge with network_valid_i=1 and network_ready_o=1.
REQ-007 FSM: two states, IDLE (expect header) and PAYLOAD.
REQ-008 FSM transitions:
- IDLE + HEADER: latch tid/tdest, clear the flit index, go to PAYLOAD.
- IDLE + HEADER_TAIL: discard the flit, stay in IDLE, no output, no error.
- IDLE + BODY/TAIL: discard the flit, set protocol_error_o.
REQ-009 In PAYLOAD, data flit k of a beat, with k in 0..R-1 and R = TDataWidth/FlitWidth, SHALL occupy tdata[k*FlitWidth +: FlitWidth], least significant first.
REQ-010 A beat SHALL be pushed into the output queue when the R-th flit is consumed or when a TAIL is consumed.
- tkeep SHALL mark the bytes of filled flit slots.
- Unfilled lanes SHALL be zero.
- tlast=1 only for a TAIL-closed beat.
- tid/tdest SHALL be the latched header values.
REQ-011 After consuming a TAIL, the FSM SHALL return to IDLE.
REQ-012 HEADER or HEADER_TAIL in PAYLOAD:
- Discard the partial beat (never emitted) and set protocol_error_o.
- Then process the flit as in IDLE.
REQ-013 Output queue: 2-entry FIFO.
- m_axis_tvalid_o = FIFO non-empty; outputs SHALL be driven from the head entry.
- Pop on m_axis_tvalid_o & m_axis_tready_i.
REQ-014 network_ready_o SHALL be the inverse of FIFO full (2 entries), for every flit type, with no combinational path from m_axis_tready_i or network_valid_i.
REQ-015 Simultaneous push and pop SHALL leave the FIFO count unchanged, with order preserved.
REQ-016 Latency: a beat completed at edge t SHALL show m_axis_tvalid_o=1 after edge t.
REQ-017 With R=1 and m_axis_tready_i held at 1, throughput SHALL be one flit per cycle.
REQ-018 Head outputs SHALL remain stable while m_axis_tvalid_o=1 and m_axis_tready_i=0.
REQ-019 protocol_error_o SHALL remain 1 once set, until reset.

Reset
REQ-020 While rst_axis_ni=0, all of the following SHALL hold:
- FSM=IDLE, flit index=0, FIFO empty.
- m_axis_tvalid_o=0; tdata/tkeep/tlast/tid/tdest=0.
- protocol_error_o=0, network_ready_o=0.
REQ-021 On reset release, network_ready_o SHALL rise to 1 on the first edge.
REQ-022 Reset asserted mid-packet SHALL discard all partial and queued data; no beat of that packet SHALL appear afterwards.

Verification (defaults, R=2)
REQ-023 Normal packet:
- Stimulus: HEADER(tdest=3, tid=5), BODY 0x1111, BODY 0x2222, TAIL 0x3333.
- Response: beat 0x22221111 keep=0xF last=0, then beat 0x00003333 keep=0x3 last=1; both tid=5, tdest=3.
REQ-024 Backpressure:
- Stimulus: m_axis_tready_i=0, packet of 6 BODY flits.
- Response: network_ready_o=0 after 2 beats are queued; no data is lost once tready=1; beat order is preserved.
REQ-025 Orphan data:
- Stimulus: BODY 0xAAAA in IDLE.
- Response: no m_axis_tvalid_o, protocol_error_o=1, and it stays 1.
REQ-026 HEADER_TAIL in IDLE -> no output and protocol_error_o=0.
REQ-027 Header mid-packet:
- Stimulus: HEADER(tdest=1), BODY 0x1111, HEADER(tdest=2), BODY 0x4444, TAIL 0x5555.
- Response: a single beat 0x55554444 keep=0xF last=1 tdest=2; protocol_error_o=1.
REQ-028 Reset mid-packet:
- Stimulus: assert rst_axis_ni=0 after HEADER + BODY.
- Response: outputs zero; after release, a clean packet from REQ-023 gives the identical result.

Source files
------------

// File: rtl/net_toaxistream.sv
// Turns a network flit stream (HEADER / BODY / TAIL / HEADER_TAIL) into AXI4-Stream beats.
// Data flits are packed least-significant first into a beat, then queued in a 2-entry output FIFO.
module net_toaxistream #(
  parameter int AxiStreamIfTDataWidth          = 32,
  parameter int AxiStreamIfTIdWidth            = 4,
  parameter int AxiStreamIfTDestWidth          = 4,
  parameter int NetworkIfFlitWidth             = 16,
  parameter int NetworkIfFlitTypeWidth         = 2,
  parameter int NetworkIfBroadcastWidth        = 1,
  parameter int NetworkIfVirtualChannelIdWidth = 1
) (
  input  logic                                      clk_axis_i,
  input  logic                                      rst_axis_ni,
  input  logic                                      network_valid_i,
  output logic                                      network_ready_o,
  input  logic [NetworkIfFlitWidth-1:0]             network_flit_i,
  input  logic [NetworkIfFlitTypeWidth-1:0]         network_flit_type_i,
  input  logic [NetworkIfBroadcastWidth-1:0]        network_broadcast_i,
  input  logic [NetworkIfVirtualChannelIdWidth-1:0] network_virtual_channel_id_i,
  output logic                                      m_axis_tvalid_o,
  input  logic                                      m_axis_tready_i,
  output logic [AxiStreamIfTDataWidth-1:0]          m_axis_tdata_o,
  output logic [AxiStreamIfTDataWidth/8-1:0]        m_axis_tkeep_o,
  output logic                                      m_axis_tlast_o,
  output logic [AxiStreamIfTIdWidth-1:0]            m_axis_tid_o,
  output logic [AxiStreamIfTDestWidth-1:0]          m_axis_tdest_o,
  output logic                                      protocol_error_o
);

  localparam int DataW     = AxiStreamIfTDataWidth;
  localparam int FlitW     = NetworkIfFlitWidth;
  localparam int KeepW     = DataW / 8;
  localparam int FlitBytes = FlitW / 8;
  localparam int Ratio     = DataW / FlitW;
  localparam int IdxW      = (Ratio > 1) ? $clog2(Ratio) : 1;

  localparam logic [1:0] FT_HEADER      = 2'd0;
  localparam logic [1:0] FT_BODY        = 2'd1;
  localparam logic [1:0] FT_TAIL        = 2'd2;
  localparam logic [1:0] FT_HEADER_TAIL = 2'd3;

  typedef enum logic {ST_IDLE, ST_PAYLOAD} state_e;

  state_e                           state_q;
  logic [IdxW-1:0]                  idx_q;
  logic [DataW-1:0]                 acc_data_q;
  logic [KeepW-1:0]                 acc_keep_q;
  logic [AxiStreamIfTIdWidth-1:0]   tid_q;
  logic [AxiStreamIfTDestWidth-1:0] tdest_q;
  logic                             err_q;
  logic                             ready_q;

  logic [DataW-1:0]                 fifo_data_q  [2];
  logic [KeepW-1:0]                 fifo_keep_q  [2];
  logic                             fifo_last_q  [2];
  logic [AxiStreamIfTIdWidth-1:0]   fifo_tid_q   [2];
  logic [AxiStreamIfTDestWidth-1:0] fifo_tdest_q [2];
  logic                             wr_ptr_q;
  logic                             rd_ptr_q;
  logic [1:0]                       count_q;

  logic             fire;
  logic [1:0]       ftype;
  logic             idx_last;
  logic             push;
  logic             pop;
  logic [1:0]       count_next;
  logic [DataW-1:0] beat_data;
  logic [KeepW-1:0] beat_keep;

  // Handshake: a flit moves on a rising edge with network_valid_i & network_ready_o; a beat
  // moves on m_axis_tvalid_o & m_axis_tready_i. Ready is registered, so it never depends on valid.
  assign fire     = network_valid_i & ready_q;
  assign ftype    = network_flit_type_i[1:0];
  assign idx_last = (int'(idx_q) == Ratio - 1);
  assign push     = fire && (state_q == ST_PAYLOAD) &&
                    ((ftype == FT_TAIL) || ((ftype == FT_BODY) && idx_last));
  assign pop      = (count_q != 2'd0) & m_axis_tready_i;
  assign count_next = count_q + {1'b0, push} - {1'b0, pop};

  // Current partial beat with the incoming flit merged into its slot.
  always_comb begin
    beat_data = acc_data_q;
    beat_keep = acc_keep_q;
    for (int k = 0; k < Ratio; k++) begin
      if (int'(idx_q) == k) begin
        beat_data[k*FlitW +: FlitW]         = network_flit_i;
        beat_keep[k*FlitBytes +: FlitBytes] = '1;
      end
    end
  end

  always_ff @(posedge clk_axis_i or negedge rst_axis_ni) begin
    if (!rst_axis_ni) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      acc_data_q <= '0;
      acc_keep_q <= '0;
      tid_q      <= '0;
      tdest_q    <= '0;
      err_q      <= 1'b0;
    end else if (fire) begin
      case (state_q)
        ST_IDLE: begin
          case (ftype)
            FT_HEADER: begin
              tdest_q    <= network_flit_i[AxiStreamIfTDestWidth-1:0];
              tid_q      <= network_flit_i[AxiStreamIfTDestWidth +: AxiStreamIfTIdWidth];
              idx_q      <= '0;
              acc_data_q <= '0;
              acc_keep_q <= '0;
              state_q    <= ST_PAYLOAD;
            end
            FT_HEADER_TAIL: ;
            default: err_q <= 1'b1;
          endcase
        end
        ST_PAYLOAD: begin
          case (ftype)
            // A new header aborts the open packet; its partial beat is dropped.
            FT_HEADER: begin
              err_q      <= 1'b1;
              tdest_q    <= network_flit_i[AxiStreamIfTDestWidth-1:0];
              tid_q      <= network_flit_i[AxiStreamIfTDestWidth +: AxiStreamIfTIdWidth];
              idx_q      <= '0;
              acc_data_q <= '0;
              acc_keep_q <= '0;
            end
            FT_HEADER_TAIL: begin
              err_q      <= 1'b1;
              idx_q      <= '0;
              acc_data_q <= '0;
              acc_keep_q <= '0;
              state_q    <= ST_IDLE;
            end
            FT_BODY: begin
              if (idx_last) begin
                idx_q      <= '0;
                acc_data_q <= '0;
                acc_keep_q <= '0;
              end else begin
                idx_q      <= idx_q + 1'b1;
                acc_data_q <= beat_data;
                acc_keep_q <= beat_keep;
              end
            end
            default: begin
              idx_q      <= '0;
              acc_data_q <= '0;
              acc_keep_q <= '0;
              state_q    <= ST_IDLE;
            end
          endcase
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_axis_i or negedge rst_axis_ni) begin
    if (!rst_axis_ni) begin
      for (int i = 0; i < 2; i++) begin
        fifo_data_q[i]  <= '0;
        fifo_keep_q[i]  <= '0;
        fifo_last_q[i]  <= 1'b0;
        fifo_tid_q[i]   <= '0;
        fifo_tdest_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      ready_q  <= 1'b0;
    end else begin
      if (push) begin
        fifo_data_q[wr_ptr_q]  <= beat_data;
        fifo_keep_q[wr_ptr_q]  <= beat_keep;
        fifo_last_q[wr_ptr_q]  <= (ftype == FT_TAIL);
        fifo_tid_q[wr_ptr_q]   <= tid_q;
        fifo_tdest_q[wr_ptr_q] <= tdest_q;
        wr_ptr_q               <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_next;
      ready_q <= (count_next != 2'd2);
    end
  end

  assign network_ready_o  = ready_q;
  assign protocol_error_o = err_q;
  assign m_axis_tvalid_o  = (count_q != 2'd0);
  assign m_axis_tdata_o   = m_axis_tvalid_o ? fifo_data_q[rd_ptr_q]  : '0;
  assign m_axis_tkeep_o   = m_axis_tvalid_o ? fifo_keep_q[rd_ptr_q]  : '0;
  assign m_axis_tlast_o   = m_axis_tvalid_o ? fifo_last_q[rd_ptr_q]  : 1'b0;
  assign m_axis_tid_o     = m_axis_tvalid_o ? fifo_tid_q[rd_ptr_q]   : '0;
  assign m_axis_tdest_o   = m_axis_tvalid_o ? fifo_tdest_q[rd_ptr_q] : '0;

  // Broadcast and VC id carry nothing for a single-VC endpoint.
  logic unused_inputs;
  assign unused_inputs = ^{network_broadcast_i, network_virtual_channel_id_i, network_flit_type_i};

endmodule

// File: tb/tb_net_toaxistream.sv
// Bench for net_toaxistream at default parameters (two 16-bit flits per 32-bit beat).
// Directed packets plus a randomized flit stream scored against a packet-level model.
module tb_net_toaxistream;

  localparam int R = 2;
  localparam int BeatW = 4 + 4 + 1 + 4 + 32;

  logic        clk_axis_i = 1'b0;
  logic        rst_axis_ni = 1'b0;
  logic        network_valid_i = 1'b0;
  logic        network_ready_o;
  logic [15:0] network_flit_i = '0;
  logic [1:0]  network_flit_type_i = '0;
  logic [0:0]  network_broadcast_i = '0;
  logic [0:0]  network_virtual_channel_id_i = '0;
  logic        m_axis_tvalid_o;
  logic        m_axis_tready_i = 1'b1;
  logic [31:0] m_axis_tdata_o;
  logic [3:0]  m_axis_tkeep_o;
  logic        m_axis_tlast_o;
  logic [3:0]  m_axis_tid_o;
  logic [3:0]  m_axis_tdest_o;
  logic        protocol_error_o;

  net_toaxistream dut (
    .clk_axis_i                   (clk_axis_i),
    .rst_axis_ni                  (rst_axis_ni),
    .network_valid_i              (network_valid_i),
    .network_ready_o              (network_ready_o),
    .network_flit_i               (network_flit_i),
    .network_flit_type_i          (network_flit_type_i),
    .network_broadcast_i          (network_broadcast_i),
    .network_virtual_channel_id_i (network_virtual_channel_id_i),
    .m_axis_tvalid_o              (m_axis_tvalid_o),
    .m_axis_tready_i              (m_axis_tready_i),
    .m_axis_tdata_o               (m_axis_tdata_o),
    .m_axis_tkeep_o               (m_axis_tkeep_o),
    .m_axis_tlast_o               (m_axis_tlast_o),
    .m_axis_tid_o                 (m_axis_tid_o),
    .m_axis_tdest_o               (m_axis_tdest_o),
    .protocol_error_o             (protocol_error_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_axis_i = ~clk_axis_i;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [BeatW-1:0] exp_q[$];
  logic [BeatW-1:0] got_q[$];
  bit rand_ready = 0;

  // packet-level reference model state
  bit          m_in_pkt = 0;
  bit          m_err = 0;
  logic [3:0]  m_tid = '0;
  logic [3:0]  m_tdest = '0;
  logic [15:0] cur_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [BeatW-1:0] mk_beat(input logic [3:0] dest, input logic [3:0] id,
                                               input bit last, input logic [3:0] keep,
                                               input logic [31:0] data);
    return {dest, id, last, keep, data};
  endfunction

  function automatic void model_emit(input bit last);
    logic [31:0] data = '0;
    logic [3:0]  keep = '0;
    for (int i = 0; i < cur_q.size(); i++) begin
      data = data | (32'(cur_q[i]) << (16 * i));
      keep = keep | (4'b0011 << (2 * i));
    end
    exp_q.push_back(mk_beat(m_tdest, m_tid, last, keep, data));
    cur_q.delete();
  endfunction

  function automatic void model_consume(input logic [1:0] t, input logic [15:0] d);
    case (t)
      2'd0: begin
        if (m_in_pkt) m_err = 1;
        cur_q.delete();
        m_in_pkt = 1;
        m_tdest  = d[3:0];
        m_tid    = d[7:4];
      end
      2'd3: begin
        if (m_in_pkt) m_err = 1;
        cur_q.delete();
        m_in_pkt = 0;
      end
      default: begin
        if (!m_in_pkt) m_err = 1;
        else begin
          cur_q.push_back(d);
          if (t == 2'd2 || cur_q.size() == R) model_emit(t == 2'd2);
          if (t == 2'd2) m_in_pkt = 0;
        end
      end
    endcase
  endfunction

  function automatic void model_flush();
    exp_q.delete();
    got_q.delete();
    cur_q.delete();
    m_in_pkt = 0;
    m_err    = 0;
  endfunction

  // Monitor: sample half a cycle away from the active edge, when tready/tvalid are settled.
  always @(negedge clk_axis_i) begin
    #1;
    if (rst_axis_ni && m_axis_tvalid_o && m_axis_tready_i) begin
      logic [BeatW-1:0] got;
      got = mk_beat(m_axis_tdest_o, m_axis_tid_o, m_axis_tlast_o, m_axis_tkeep_o, m_axis_tdata_o);
      got_q.push_back(got);
      if (exp_q.size() == 0) check("unexpected_beat", 64'(got), 64'(0) - 1);
      else check("beat", 64'(got), 64'(exp_q.pop_front()));
    end
  end

  always @(negedge clk_axis_i) begin
    if (rand_ready) m_axis_tready_i = 1'($urandom_range(0, 1));
  end

  // ---------------- driver tasks ----------------
  task automatic send_flit(input logic [1:0] t, input logic [15:0] d);
    int n = 0;
    @(negedge clk_axis_i);
    network_valid_i     = 1'b1;
    network_flit_type_i = t;
    network_flit_i      = d;
    #1;
    while (!network_ready_o && n < 300) begin
      @(negedge clk_axis_i);
      #1;
      n++;
    end
    if (!network_ready_o) begin
      check("flit_accept_timeout", 64'(0), 64'(1));
      network_valid_i = 1'b0;
      return;
    end
    model_consume(t, d);
    @(posedge clk_axis_i);
    #1;
    network_valid_i = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk_axis_i);
    network_valid_i = 1'b0;
    rst_axis_ni     = 1'b0;
    model_flush();
    #1;
    check("rst_tvalid", 64'(m_axis_tvalid_o), 64'(0));
    check("rst_outputs", 64'({m_axis_tdata_o, m_axis_tkeep_o, m_axis_tlast_o, m_axis_tid_o, m_axis_tdest_o}), 64'(0));
    check("rst_err", 64'(protocol_error_o), 64'(0));
    check("rst_ready", 64'(network_ready_o), 64'(0));
    repeat (2) @(negedge clk_axis_i);
    rst_axis_ni = 1'b1;
    #1;
    check("ready_before_edge", 64'(network_ready_o), 64'(0));
    @(negedge clk_axis_i);
    #1;
    check("ready_after_release", 64'(network_ready_o), 64'(1));
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk_axis_i);
      n++;
    end
    repeat (3) @(negedge clk_axis_i);
    check(tag, 64'(exp_q.size()), 64'(0));
    #2;
    check({tag, "_idle"}, 64'(m_axis_tvalid_o), 64'(0));
  endtask

  task automatic send_normal_packet();
    send_flit(2'd0, 16'h0053);
    send_flit(2'd1, 16'h1111);
    send_flit(2'd1, 16'h2222);
    send_flit(2'd2, 16'h3333);
  endtask

  task automatic check_normal_result(input string tag);
    check({tag, "_count"}, 64'(got_q.size()), 64'(2));
    if (got_q.size() == 2) begin
      check({tag, "_beat0"}, 64'(got_q[0]), 64'(mk_beat(4'd3, 4'd5, 1'b0, 4'hF, 32'h22221111)));
      check({tag, "_beat1"}, 64'(got_q[1]), 64'(mk_beat(4'd3, 4'd5, 1'b1, 4'h3, 32'h00003333)));
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [BeatW-1:0] snap;
    int r;
    logic [1:0] t;

    do_reset();

    // normal packet
    m_axis_tready_i = 1'b1;
    send_normal_packet();
    wait_drain("normal_drain");
    check_normal_result("normal");
    check("normal_err", 64'(protocol_error_o), 64'(0));

    // HEADER_TAIL while idle: silently dropped
    got_q.delete();
    send_flit(2'd3, 16'hBEEF);
    wait_drain("ht_drain");
    check("ht_no_output", 64'(got_q.size()), 64'(0));
    check("ht_err", 64'(protocol_error_o), 64'(0));

    // backpressure: six bodies plus a closing tail with the sink stalled
    m_axis_tready_i = 1'b0;
    send_flit(2'd0, 16'h0027);
    fork
      begin
        for (int i = 0; i < 6; i++) send_flit(2'd1, 16'hC000 + 16'(i));
        send_flit(2'd2, 16'h7777);
      end
      begin
        repeat (20) @(negedge clk_axis_i);
        #2;
        check("bp_ready_low", 64'(network_ready_o), 64'(0));
        check("bp_tvalid", 64'(m_axis_tvalid_o), 64'(1));
        snap = mk_beat(m_axis_tdest_o, m_axis_tid_o, m_axis_tlast_o, m_axis_tkeep_o, m_axis_tdata_o);
        repeat (3) @(negedge clk_axis_i);
        #2;
        check("bp_head_stable", 64'(mk_beat(m_axis_tdest_o, m_axis_tid_o, m_axis_tlast_o,
                                            m_axis_tkeep_o, m_axis_tdata_o)), 64'(snap));
        @(negedge clk_axis_i);
        m_axis_tready_i = 1'b1;
      end
    join
    wait_drain("bp_drain");
    check("bp_err", 64'(protocol_error_o), 64'(0));

    // orphan data in IDLE
    got_q.delete();
    send_flit(2'd1, 16'hAAAA);
    wait_drain("orphan_drain");
    check("orphan_no_output", 64'(got_q.size()), 64'(0));
    check("orphan_err", 64'(protocol_error_o), 64'(1));
    repeat (5) @(negedge clk_axis_i);
    check("orphan_err_sticky", 64'(protocol_error_o), 64'(1));

    // header arriving mid-packet
    do_reset();
    send_flit(2'd0, 16'h0001);
    send_flit(2'd1, 16'h1111);
    send_flit(2'd0, 16'h0002);
    send_flit(2'd1, 16'h4444);
    send_flit(2'd2, 16'h5555);
    wait_drain("midhdr_drain");
    check("midhdr_count", 64'(got_q.size()), 64'(1));
    if (got_q.size() == 1)
      check("midhdr_beat", 64'(got_q[0]), 64'(mk_beat(4'd2, 4'd0, 1'b1, 4'hF, 32'h55554444)));
    check("midhdr_err", 64'(protocol_error_o), 64'(1));

    // reset mid-packet, then a clean packet
    do_reset();
    send_flit(2'd0, 16'h0053);
    send_flit(2'd1, 16'h9999);
    do_reset();
    send_normal_packet();
    wait_drain("rstmid_drain");
    check_normal_result("rstmid");
    check("rstmid_err", 64'(protocol_error_o), 64'(0));

    // randomized stream with random sink backpressure
    do_reset();
    rand_ready = 1;
    send_flit(2'd0, 16'($urandom));
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      t = (r < 8) ? 2'd0 : (r < 11) ? 2'd3 : (r < 75) ? 2'd1 : 2'd2;
      send_flit(t, 16'($urandom));
      check("rand_err", 64'(protocol_error_o), 64'(m_err));
      if ($urandom_range(0, 3) == 0) @(negedge clk_axis_i);
    end
    @(negedge clk_axis_i);
    rand_ready = 0;
    m_axis_tready_i = 1'b1;
    wait_drain("rand_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
